uart_tx_sequencer: RTL and testbench



---
 rtl/uart_tx_sequencer_pkg.sv | 28 ++
 rtl/uart_tx_sequencer_if.sv | 21 ++
 rtl/uart_tx_sequencer_fifo.sv | 61 ++++++
 rtl/uart_tx_sequencer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sequencer_pkg.sv
// rtl/uart_tx_sequencer_pkg.sv - shared constants, FSM state type and status helper for the UART TX sequencer
package uart_tx_sequencer_pkg;

  localparam int ADDR_W = 32;
  localparam int XLEN   = 32;

  localparam logic [ADDR_W-1:0] IO_BASE_ADDR        = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] IO_UART_TX_OFFSET   = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] IO_UART_STAT_OFFSET = 32'h0000_0008;
  localparam int                UART_STAT_BUSY_BIT  = 0;

  localparam logic [ADDR_W-1:0] UART_STAT_ADDR = IO_BASE_ADDR + IO_UART_STAT_OFFSET;
  localparam logic [ADDR_W-1:0] UART_TX_ADDR   = IO_BASE_ADDR + IO_UART_TX_OFFSET;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_POLL_WAIT,
    ST_GAP,
    ST_WRITE,
    ST_WRITE_WAIT
  } seq_state_e;

  function automatic logic uart_busy(input logic [XLEN-1:0] stat);
    return stat[UART_STAT_BUSY_BIT];
  endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// rtl/uart_tx_sequencer_if.sv - MMIO request/response bus between the sequencer and the peripheral
import uart_tx_sequencer_pkg::*;

interface uart_tx_sequencer_if;
  logic              mmio_req;
  logic              mmio_we;
  logic [ADDR_W-1:0] mmio_addr;
  logic [XLEN-1:0]   mmio_wdata;
  logic [XLEN-1:0]   mmio_rdata;
  logic              mmio_ready;

  modport master (
    output mmio_req, mmio_we, mmio_addr, mmio_wdata,
    input  mmio_rdata, mmio_ready
  );

  modport slave (
    input  mmio_req, mmio_we, mmio_addr, mmio_wdata,
    output mmio_rdata, mmio_ready
  );
endinterface

// File: rtl/uart_tx_sequencer_fifo.sv
// rtl/uart_tx_sequencer_fifo.sv - byte FIFO with flush; a pop frees a slot for a same-cycle push when full
module seq_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - two-requester byte arbiter feeding a FIFO drained to the UART by a status-polling MMIO master
import uart_tx_sequencer_pkg::*;

module uart_tx_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_valid,
  input  logic [7:0]                    a_data,
  output logic                          a_ready,
  input  logic                          b_valid,
  input  logic [7:0]                    b_data,
  output logic                          b_ready,
  input  logic                          flush,
  uart_tx_sequencer_if.master           mmio,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          seq_busy,
  output logic                          drop_pulse,
  output logic [15:0]                   drop_cnt
);
  seq_state_e        state_q;
  logic              prio_b_q;
  logic [15:0]       poll_cnt_q;
  logic [15:0]       gap_cnt_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              drop_pulse_q;
  logic [15:0]       drop_cnt_q;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       can_push;
  logic       grant_a;
  logic       grant_b;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       stat_done;
  logic       wr_done;
  logic       busy_bit;
  logic       limit_hit;
  logic       gap_done;
  logic       drop_now;

  assign stat_done = (state_q == ST_POLL_WAIT) && mmio.mmio_ready;
  assign wr_done   = (state_q == ST_WRITE_WAIT) && mmio.mmio_ready;
  assign busy_bit  = uart_busy(mmio.mmio_rdata);
  assign limit_hit = (POLL_LIMIT != 0) && (({16'd0, poll_cnt_q} + 32'd1) >= 32'(POLL_LIMIT));
  assign gap_done  = ({16'd0, gap_cnt_q} + 32'd1) >= 32'(POLL_GAP);
  assign drop_now  = stat_done && busy_bit && limit_hit && !fifo_empty && !flush;
  assign pop       = wr_done || drop_now;

  // A pop this cycle opens a slot, so a full FIFO can still accept
  assign can_push  = (!fifo_full || pop) && !flush;
  assign grant_a   = can_push && a_valid && (!b_valid || !prio_b_q);
  assign grant_b   = can_push && b_valid && (!a_valid || prio_b_q);
  assign push      = grant_a || grant_b;
  assign push_data = grant_a ? a_data : b_data;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;

  seq_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign mmio.mmio_req   = req_q;
  assign mmio.mmio_we    = we_q;
  assign mmio.mmio_addr  = addr_q;
  assign mmio.mmio_wdata = wdata_q;
  assign seq_busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign drop_pulse      = drop_pulse_q;
  assign drop_cnt        = drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      prio_b_q     <= 1'b0;
      poll_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (grant_a && b_valid)      prio_b_q <= 1'b1;
      else if (grant_b && a_valid) prio_b_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          poll_cnt_q <= '0;
          if (!fifo_empty && !flush) state_q <= ST_POLL;
        end
        ST_POLL: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= UART_STAT_ADDR;
            state_q <= ST_POLL_WAIT;
          end
        end
        ST_POLL_WAIT: begin
          if (mmio.mmio_ready) begin
            req_q <= 1'b0;
            // A flushed FIFO has nothing left to send, whatever the UART says
            if (fifo_empty || flush) begin
              state_q <= ST_IDLE;
            end else if (!busy_bit) begin
              state_q <= ST_WRITE;
            end else if (limit_hit) begin
              drop_pulse_q <= 1'b1;
              if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
              state_q <= ST_IDLE;
            end else begin
              if (poll_cnt_q != 16'hFFFF) poll_cnt_q <= poll_cnt_q + 16'd1;
              gap_cnt_q <= '0;
              state_q   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (fifo_empty || flush) begin
            state_q <= ST_IDLE;
          end else if (gap_done) begin
            state_q <= ST_POLL;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        ST_WRITE: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= UART_TX_ADDR;
            wdata_q <= {{(XLEN-8){1'b0}}, fifo_head};
            state_q <= ST_WRITE_WAIT;
          end
        end
        ST_WRITE_WAIT: begin
          if (mmio.mmio_ready) begin
            req_q      <= 1'b0;
            poll_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - directed scoreboard bench for uart_tx_sequencer with MMIO slave models
import uart_tx_sequencer_pkg::*;

module tb_uart_tx_sequencer;

  logic clk;
  logic rst_n;
  int   cycle;
  int   checks;
  int   errors;

  logic       m_a_valid, m_b_valid, m_flush;
  logic [7:0] m_a_data, m_b_data;
  logic       m_a_ready, m_b_ready, m_seq_busy, m_drop_pulse;
  logic [4:0] m_level;
  logic [15:0] m_drop_cnt;

  logic       d_a_valid, d_b_valid, d_flush;
  logic [7:0] d_a_data, d_b_data;
  logic       d_a_ready, d_b_ready, d_seq_busy, d_drop_pulse;
  logic [4:0] d_level;
  logic [15:0] d_drop_cnt;

  uart_tx_sequencer_if m_if ();
  uart_tx_sequencer_if d_if ();

  uart_tx_sequencer #(.FIFO_DEPTH(16), .POLL_GAP(4), .POLL_LIMIT(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(m_a_valid), .a_data(m_a_data), .a_ready(m_a_ready),
    .b_valid(m_b_valid), .b_data(m_b_data), .b_ready(m_b_ready),
    .flush(m_flush), .mmio(m_if),
    .fifo_level(m_level), .seq_busy(m_seq_busy),
    .drop_pulse(m_drop_pulse), .drop_cnt(m_drop_cnt)
  );

  uart_tx_sequencer #(.FIFO_DEPTH(16), .POLL_GAP(1), .POLL_LIMIT(2)) u_drop (
    .clk(clk), .rst_n(rst_n),
    .a_valid(d_a_valid), .a_data(d_a_data), .a_ready(d_a_ready),
    .b_valid(d_b_valid), .b_data(d_b_data), .b_ready(d_b_ready),
    .flush(d_flush), .mmio(d_if),
    .fifo_level(d_level), .seq_busy(d_seq_busy),
    .drop_pulse(d_drop_pulse), .drop_cnt(d_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // UART slave models: one-cycle ready, busy controlled from the stimulus
  bit m_busy_stuck, d_busy_stuck;
  int m_busy_until;
  int m_stat_cnt, d_stat_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_if.mmio_ready <= 1'b0;
      m_if.mmio_rdata <= '0;
      m_stat_cnt      <= 0;
    end else begin
      m_if.mmio_ready <= 1'b0;
      if (m_if.mmio_req && !m_if.mmio_ready) begin
        m_if.mmio_ready <= 1'b1;
        if (!m_if.mmio_we) begin
          m_if.mmio_rdata <= {31'd0, m_busy_stuck || (m_stat_cnt < m_busy_until)};
          m_stat_cnt      <= m_stat_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_if.mmio_ready <= 1'b0;
      d_if.mmio_rdata <= '0;
      d_stat_cnt      <= 0;
    end else begin
      d_if.mmio_ready <= 1'b0;
      if (d_if.mmio_req && !d_if.mmio_ready) begin
        d_if.mmio_ready <= 1'b1;
        if (!d_if.mmio_we) begin
          d_if.mmio_rdata <= {31'd0, d_busy_stuck};
          d_stat_cnt      <= d_stat_cnt + 1;
        end
      end
    end
  end

  // Scoreboards and bus monitors
  logic [7:0] m_sb[$];
  logic [7:0] d_sb[$];
  int  m_reads, m_writes, d_reads, d_writes;
  int  m_last_rd_cycle;
  bit  m_last_busy;
  bit  m_req_prev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.mmio_req && !m_req_prev) begin
        if (m_if.mmio_we) begin
          chk("wr_addr", m_if.mmio_addr, UART_TX_ADDR);
          chk("wr_after_idle_status", {31'd0, m_last_busy}, 32'd0);
        end else begin
          chk("rd_addr", m_if.mmio_addr, UART_STAT_ADDR);
          if (m_last_busy)
            chk("poll_gap_ok", {31'd0, (cycle - m_last_rd_cycle - 1) >= 4}, 32'd1);
        end
      end
      if (m_if.mmio_req && m_if.mmio_ready) begin
        if (m_if.mmio_we) begin
          m_writes++;
          if (m_sb.size() == 0) chk("m_sb_underflow", 32'd1, 32'd0);
          else chk("m_wr_data", m_if.mmio_wdata, {24'd0, m_sb.pop_front()});
        end else begin
          m_reads++;
          m_last_busy     = m_if.mmio_rdata[0];
          m_last_rd_cycle = cycle;
        end
      end
      m_req_prev = m_if.mmio_req;

      if (d_if.mmio_req && d_if.mmio_ready) begin
        if (d_if.mmio_we) begin
          d_writes++;
          if (d_sb.size() == 0) chk("d_sb_underflow", 32'd1, 32'd0);
          else chk("d_wr_data", d_if.mmio_wdata, {24'd0, d_sb.pop_front()});
        end else begin
          d_reads++;
        end
      end
    end
  end

  task automatic offer(input bit sel, input bit av, input logic [7:0] ad,
                       input bit bv, input logic [7:0] bd, output bit ga, output bit gb);
    @(negedge clk);
    if (!sel) begin
      m_a_valid = av; m_a_data = ad; m_b_valid = bv; m_b_data = bd;
    end else begin
      d_a_valid = av; d_a_data = ad; d_b_valid = bv; d_b_data = bd;
    end
    #1;
    ga = sel ? d_a_ready : m_a_ready;
    gb = sel ? d_b_ready : m_b_ready;
  endtask

  task automatic release_inputs();
    @(negedge clk);
    m_a_valid = 0; m_b_valid = 0; d_a_valid = 0; d_b_valid = 0;
  endtask

  task automatic wait_idle(input bit sel, input string tag);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (sel ? (!d_seq_busy && d_level == 0) : (!m_seq_busy && m_level == 0)) done = 1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    bit ga, gb, prio_b, hit;
    int na, nb, r0, w0;
    checks = 0; errors = 0;
    m_a_valid = 0; m_b_valid = 0; m_flush = 0; m_a_data = 0; m_b_data = 0;
    d_a_valid = 0; d_b_valid = 0; d_flush = 0; d_a_data = 0; d_b_data = 0;
    m_busy_stuck = 0; d_busy_stuck = 0; m_busy_until = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_req",   {31'd0, m_if.mmio_req}, 32'd0);
    chk("rst_we",    {31'd0, m_if.mmio_we}, 32'd0);
    chk("rst_addr",  m_if.mmio_addr, 32'd0);
    chk("rst_wdata", m_if.mmio_wdata, 32'd0);
    chk("rst_ready", {30'd0, m_a_ready, m_b_ready}, 32'd0);
    chk("rst_level", {27'd0, m_level}, 32'd0);
    chk("rst_busy",  {31'd0, m_seq_busy}, 32'd0);
    chk("rst_drop",  {15'd0, m_drop_pulse, m_drop_cnt}, 32'd0);
    rst_n = 1;

    // Single byte, UART idle
    r0 = m_reads; w0 = m_writes;
    offer(0, 1, 8'h41, 0, 8'h00, ga, gb);
    chk("t1_accept", {31'd0, ga}, 32'd1);
    m_sb.push_back(8'h41);
    release_inputs();
    wait_idle(0, "t1_drain");
    chk("t1_reads",  m_reads - r0, 32'd1);
    chk("t1_writes", m_writes - w0, 32'd1);
    chk("t1_level",  {27'd0, m_level}, 32'd0);

    // Both requesters streaming: strict alternation starting with A
    prio_b = 0; na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      offer(0, 1, 8'(8'h10 + na), 1, 8'(8'h20 + nb), ga, gb);
      chk("t2_grant_a", {31'd0, ga}, {31'd0, !prio_b});
      chk("t2_grant_b", {31'd0, gb}, {31'd0, prio_b});
      m_sb.push_back(prio_b ? 8'(8'h20 + nb) : 8'(8'h10 + na));
      if (ga) na++;
      if (gb) nb++;
      prio_b = !prio_b;
    end
    release_inputs();
    wait_idle(0, "t2_drain");
    chk("t2_sb_empty", m_sb.size(), 32'd0);

    // Fill while busy, then a pop lets exactly one byte in
    m_busy_stuck = 1;
    for (int i = 0; i < 16; i++) begin
      offer(0, 1, 8'(8'h30 + i), 0, 8'h00, ga, gb);
      chk("t3_fill_ready", {31'd0, ga}, 32'd1);
      m_sb.push_back(8'(8'h30 + i));
    end
    offer(0, 1, 8'h99, 1, 8'h98, ga, gb);
    chk("t3_full_ready", {30'd0, ga, gb}, 32'd0);
    chk("t3_full_level", {27'd0, m_level}, 32'd16);
    m_busy_stuck = 0;
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      offer(0, 1, 8'h99, 0, 8'h00, ga, gb);
      if (ga) begin
        hit = 1;
        chk("t3_pop_level", {27'd0, m_level}, 32'd16);
        chk("t3_pop_is_write", {30'd0, m_if.mmio_ready, m_if.mmio_we}, 32'd3);
        m_sb.push_back(8'h99);
      end
    end
    chk("t3_accept_on_pop", {31'd0, hit}, 32'd1);
    release_inputs();
    chk("t3_level_after", {27'd0, m_level}, 32'd16);
    wait_idle(0, "t3_drain");
    chk("t3_sb_empty", m_sb.size(), 32'd0);

    // Three busy polls before the write
    r0 = m_reads; w0 = m_writes;
    m_busy_until = m_stat_cnt + 3;
    offer(0, 1, 8'h55, 0, 8'h00, ga, gb);
    chk("t4_accept", {31'd0, ga}, 32'd1);
    m_sb.push_back(8'h55);
    release_inputs();
    wait_idle(0, "t4_drain");
    chk("t4_reads",  m_reads - r0, 32'd4);
    chk("t4_writes", m_writes - w0, 32'd1);

    // Poll limit 2 with a stuck-busy UART drops the head byte
    d_busy_stuck = 1;
    offer(1, 1, 8'hA1, 0, 8'h00, ga, gb);
    chk("t5_accept0", {31'd0, ga}, 32'd1);
    offer(1, 1, 8'hA2, 0, 8'h00, ga, gb);
    chk("t5_accept1", {31'd0, ga}, 32'd1);
    d_sb.push_back(8'hA2);
    release_inputs();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (d_drop_pulse) hit = 1;
    end
    chk("t5_drop_seen", {31'd0, hit}, 32'd1);
    chk("t5_drop_cnt",  {16'd0, d_drop_cnt}, 32'd1);
    chk("t5_level",     {27'd0, d_level}, 32'd1);
    chk("t5_polls",     d_reads, 32'd2);
    @(negedge clk);
    chk("t5_pulse_one_cycle", {31'd0, d_drop_pulse}, 32'd0);
    d_busy_stuck = 0;
    wait_idle(1, "t5_drain");
    chk("t5_writes",     d_writes, 32'd1);
    chk("t5_sb_empty",   d_sb.size(), 32'd0);
    chk("t5_drop_final", {16'd0, d_drop_cnt}, 32'd1);

    // Flush during a write in flight
    r0 = m_reads; w0 = m_writes;
    for (int i = 0; i < 5; i++) begin
      offer(0, 1, 8'(8'h60 + i), 0, 8'h00, ga, gb);
      chk("t6_accept", {31'd0, ga}, 32'd1);
      m_sb.push_back(8'(8'h60 + i));
    end
    release_inputs();
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_if.mmio_req && m_if.mmio_we && !m_if.mmio_ready) hit = 1;
      else @(negedge clk);
    end
    chk("t6_write_seen", {31'd0, hit}, 32'd1);
    m_flush = 1;
    while (m_sb.size() > 1) void'(m_sb.pop_back());
    @(negedge clk);
    m_flush = 0;
    chk("t6_level_flushed", {27'd0, m_level}, 32'd0);
    repeat (40) @(negedge clk);
    chk("t6_writes",   m_writes - w0, 32'd1);
    chk("t6_reads",    m_reads - r0, 32'd1);
    chk("t6_level",    {27'd0, m_level}, 32'd0);
    chk("t6_idle",     {31'd0, m_seq_busy}, 32'd0);
    chk("t6_no_req",   {31'd0, m_if.mmio_req}, 32'd0);
    chk("t6_sb_empty", m_sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
